// File: rtl/cajero_pkg.sv
// rtl/cajero_pkg.sv - shared types and constants for the parametrised ATM controller
//   Contents: estado_t state encoding, TIPO_DEPOSITO/TIPO_RETIRO codes for tipo_trans,
//   default parameter values used by cajero_automatico_param.
package cajero_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PIN   = 3'd1,
      ST_CHECK = 3'd2,
      ST_TRANS = 3'd3,
      ST_EXEC  = 3'd4,
      ST_LOCK  = 3'd5
   } estado_t;

   localparam logic TIPO_DEPOSITO = 1'b0;
   localparam logic TIPO_RETIRO   = 1'b1;

   localparam int PIN_DIGITS_DEF   = 4;
   localparam int MAX_INTENTOS_DEF = 3;
   localparam int MONTO_W_DEF      = 32;
   localparam int BALANCE_W_DEF    = 64;
   localparam int TIMEOUT_CYC_DEF  = 1024;

endpackage

// File: rtl/cajero_pin_collector.sv
// rtl/cajero_pin_collector.sv - PIN digit shift register with digit counter
//   clk, reset (async, active-low)
//   clear          : hold collector empty (driven while the FSM is not collecting)
//   digito_stb     : accept digito this cycle
//   digito[3:0]    : digit, most significant digit first, shifted in at the LSB
//   pin_capturado  : collected digits, 4*PIN_DIGITS bits
//   done           : the strobe this cycle carries the last digit of the PIN
module cajero_pin_collector #(
   parameter int PIN_DIGITS = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear,
   input  logic                    digito_stb,
   input  logic [3:0]              digito,
   output logic [4*PIN_DIGITS-1:0] pin_capturado,
   output logic                    done
);

   localparam int CNT_W = $clog2(PIN_DIGITS + 1);
   localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(PIN_DIGITS - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pin_capturado <= '0;
         cnt           <= '0;
      end else if (clear) begin
         pin_capturado <= '0;
         cnt           <= '0;
      end else if (digito_stb) begin
         pin_capturado <= (pin_capturado << 4) | (4*PIN_DIGITS)'(digito);
         cnt           <= cnt + 1'b1;
      end
   end

   // Combinational so the FSM reaches CHECK the cycle after the last strobe,
   // while pin_capturado already holds the complete PIN.
   assign done = digito_stb && !clear && (cnt == ULTIMO);

endmodule

// File: rtl/cajero_automatico_param.sv
// rtl/cajero_automatico_param.sv - parametrised ATM controller: PIN check, lockout, deposit/withdrawal
//   Optional feature macro: SESION_TIMEOUT_EN (inactivity timeout in PIN/TRANS).
//   clk, reset (async, active-low)
//   tarjeta_recibida          : card present, sampled in IDLE
//   digito_stb, digito        : PIN digit strobe and value
//   pin_correcto              : stored PIN for the card
//   monto_stb, tipo_trans,
//   monto, balance_inicial    : transaction request (0 deposit, 1 withdrawal)
//   pin_incorrecto            : pulse per wrong PIN
//   advertencia               : level, one attempt left
//   bloqueo                   : level, card locked until reset
//   balance_actualizado       : registered result, balance_stb marks it valid
//   entregar_dinero           : pulse, dispense
//   fondos_insuficientes      : pulse, withdrawal rejected
//   sesion_expirada           : pulse, inactivity timeout (0 when the macro is undefined)
module cajero_automatico_param
   import cajero_pkg::*;
#(
   parameter int PIN_DIGITS   = PIN_DIGITS_DEF,
   parameter int MAX_INTENTOS = MAX_INTENTOS_DEF,
   parameter int MONTO_W      = MONTO_W_DEF,
   parameter int BALANCE_W    = BALANCE_W_DEF,
   parameter int TIMEOUT_CYC  = TIMEOUT_CYC_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    tarjeta_recibida,
   input  logic                    digito_stb,
   input  logic [3:0]              digito,
   input  logic [4*PIN_DIGITS-1:0] pin_correcto,
   input  logic                    tipo_trans,
   input  logic [MONTO_W-1:0]      monto,
   input  logic                    monto_stb,
   input  logic [BALANCE_W-1:0]    balance_inicial,
   output logic                    pin_incorrecto,
   output logic                    advertencia,
   output logic                    bloqueo,
   output logic [BALANCE_W-1:0]    balance_actualizado,
   output logic                    balance_stb,
   output logic                    entregar_dinero,
   output logic                    fondos_insuficientes,
   output logic                    sesion_expirada
);

   if (MAX_INTENTOS < 2 || BALANCE_W < MONTO_W || TIMEOUT_CYC < 1) begin : g_param_check
      $error("cajero_automatico_param: illegal parameter combination");
   end

   localparam int INT_W = $clog2(MAX_INTENTOS + 1);
   localparam logic [INT_W-1:0] INT_MAX   = INT_W'(MAX_INTENTOS);
   localparam logic [INT_W-1:0] INT_AVISO = INT_W'(MAX_INTENTOS - 1);

   estado_t                 estado, estado_d;
   logic [INT_W-1:0]        intentos, intentos_d, intentos_inc;
   logic                    advertencia_d, bloqueo_d, pin_inc_d;
   logic                    balance_stb_d, entregar_d, fondos_d, sesion_d;
   logic [BALANCE_W-1:0]    balance_d;
   logic                    tipo_q, tipo_d;
   logic [BALANCE_W-1:0]    monto_q, monto_d, saldo_q, saldo_d;
   logic [BALANCE_W:0]      suma;
   logic [4*PIN_DIGITS-1:0] pin_capturado;
   logic                    pin_done;
   logic                    tmo_hit;

   cajero_pin_collector #(.PIN_DIGITS(PIN_DIGITS)) u_pin (
      .clk           (clk),
      .reset         (reset),
      .clear         (estado != ST_PIN),
      .digito_stb    (digito_stb),
      .digito        (digito),
      .pin_capturado (pin_capturado),
      .done          (pin_done)
   );

   // One extra bit catches deposit overflow for saturation.
   assign suma         = {1'b0, saldo_q} + {1'b0, monto_q};
   assign intentos_inc = intentos + 1'b1;

`ifdef SESION_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMO_W-1:0] tmo_cnt;
   logic             tmo_espera, tmo_actividad;

   assign tmo_espera    = (estado == ST_PIN) || (estado == ST_TRANS);
   assign tmo_actividad = ((estado == ST_PIN) && digito_stb) || ((estado == ST_TRANS) && monto_stb);
   assign tmo_hit       = tmo_espera && !tmo_actividad && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         tmo_cnt <= '0;
      else if (!tmo_espera || tmo_actividad)
         tmo_cnt <= '0;
      else
         tmo_cnt <= tmo_cnt + 1'b1;
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      estado_d      = estado;
      intentos_d    = intentos;
      advertencia_d = advertencia;
      bloqueo_d     = bloqueo;
      balance_d     = balance_actualizado;
      tipo_d        = tipo_q;
      monto_d       = monto_q;
      saldo_d       = saldo_q;
      pin_inc_d     = 1'b0;
      balance_stb_d = 1'b0;
      entregar_d    = 1'b0;
      fondos_d      = 1'b0;
      sesion_d      = 1'b0;
      case (estado)
         ST_IDLE:
            if (tarjeta_recibida) estado_d = ST_PIN;
         ST_PIN:
            if (pin_done) estado_d = ST_CHECK;
         ST_CHECK: begin
            if (pin_capturado == pin_correcto) begin
               intentos_d    = '0;
               advertencia_d = 1'b0;
               estado_d      = ST_TRANS;
            end else begin
               pin_inc_d  = 1'b1;
               intentos_d = intentos_inc;
               if (intentos_inc == INT_MAX) begin
                  // No attempts remain, so the one-left warning no longer applies.
                  bloqueo_d     = 1'b1;
                  advertencia_d = 1'b0;
                  estado_d      = ST_LOCK;
               end else begin
                  if (intentos_inc == INT_AVISO) advertencia_d = 1'b1;
                  estado_d = ST_PIN;
               end
            end
         end
         ST_TRANS:
            if (monto_stb) begin
               tipo_d   = tipo_trans;
               monto_d  = BALANCE_W'(monto);
               saldo_d  = balance_inicial;
               estado_d = ST_EXEC;
            end
         ST_EXEC: begin
            if (tipo_q == TIPO_RETIRO) begin
               if (monto_q <= saldo_q) begin
                  balance_d     = saldo_q - monto_q;
                  balance_stb_d = 1'b1;
                  entregar_d    = 1'b1;
               end else begin
                  fondos_d = 1'b1;
               end
            end else begin
               balance_d     = suma[BALANCE_W] ? '1 : suma[BALANCE_W-1:0];
               balance_stb_d = 1'b1;
            end
            estado_d = ST_IDLE;
         end
         ST_LOCK: ;
         default: estado_d = ST_IDLE;
      endcase
      if (tmo_hit) begin
         estado_d = ST_IDLE;
         sesion_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estado               <= ST_IDLE;
         intentos             <= '0;
         advertencia          <= 1'b0;
         bloqueo              <= 1'b0;
         pin_incorrecto       <= 1'b0;
         balance_actualizado  <= '0;
         balance_stb          <= 1'b0;
         entregar_dinero      <= 1'b0;
         fondos_insuficientes <= 1'b0;
         sesion_expirada      <= 1'b0;
         tipo_q               <= TIPO_DEPOSITO;
         monto_q              <= '0;
         saldo_q              <= '0;
      end else begin
         estado               <= estado_d;
         intentos             <= intentos_d;
         advertencia          <= advertencia_d;
         bloqueo              <= bloqueo_d;
         pin_incorrecto       <= pin_inc_d;
         balance_actualizado  <= balance_d;
         balance_stb          <= balance_stb_d;
         entregar_dinero      <= entregar_d;
         fondos_insuficientes <= fondos_d;
         sesion_expirada      <= sesion_d;
         tipo_q               <= tipo_d;
         monto_q              <= monto_d;
         saldo_q              <= saldo_d;
      end
   end

endmodule

// File: tb/tb_cajero_automatico_param.sv
// tb/tb_cajero_automatico_param.sv - self-checking bench for cajero_automatico_param
module tb_cajero_automatico_param;

   localparam int PD = 4;
   localparam int MI = 3;
   localparam int MW = 32;
   localparam int BW = 64;
   localparam int TC = 16;
   localparam logic [15:0] PIN_OK = 16'h1234;
   localparam logic [63:0] TOPE   = 64'hFFFF_FFFF_FFFF_FFFF;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          tarjeta_recibida = 1'b0;
   logic          digito_stb = 1'b0;
   logic [3:0]    digito = 4'd0;
   logic [15:0]   pin_correcto = PIN_OK;
   logic          tipo_trans = 1'b0;
   logic [MW-1:0] monto = '0;
   logic          monto_stb = 1'b0;
   logic [BW-1:0] balance_inicial = '0;
   logic          pin_incorrecto, advertencia, bloqueo;
   logic [BW-1:0] balance_actualizado;
   logic          balance_stb, entregar_dinero, fondos_insuficientes, sesion_expirada;

   always #5 clk = ~clk;

   cajero_automatico_param #(
      .PIN_DIGITS(PD), .MAX_INTENTOS(MI), .MONTO_W(MW), .BALANCE_W(BW), .TIMEOUT_CYC(TC)
   ) dut (
      .clk                  (clk),
      .reset                (reset),
      .tarjeta_recibida     (tarjeta_recibida),
      .digito_stb           (digito_stb),
      .digito               (digito),
      .pin_correcto         (pin_correcto),
      .tipo_trans           (tipo_trans),
      .monto                (monto),
      .monto_stb            (monto_stb),
      .balance_inicial      (balance_inicial),
      .pin_incorrecto       (pin_incorrecto),
      .advertencia          (advertencia),
      .bloqueo              (bloqueo),
      .balance_actualizado  (balance_actualizado),
      .balance_stb          (balance_stb),
      .entregar_dinero      (entregar_dinero),
      .fondos_insuficientes (fondos_insuficientes),
      .sesion_expirada      (sesion_expirada)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state: failed attempts so far, lock flag, last published balance.
   int            m_int  = 0;
   bit            m_bloq = 1'b0;
   logic [63:0]   m_bal  = '0;

   typedef struct {
      logic        tipo;
      logic [31:0] monto;
      logic [63:0] bal;
      logic [63:0] e_bal;
      logic        e_stb;
      logic        e_ent;
      logic        e_fon;
   } vec_t;

   vec_t tabla [7];

   task automatic check1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0b want %0b", name, act, exp);
      end
   endtask

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check1({tag, "_pin_incorrecto"}, pin_incorrecto, 1'b0);
      check1({tag, "_advertencia"}, advertencia, 1'b0);
      check1({tag, "_bloqueo"}, bloqueo, 1'b0);
      check64({tag, "_balance"}, balance_actualizado, 64'd0);
      check1({tag, "_balance_stb"}, balance_stb, 1'b0);
      check1({tag, "_entregar"}, entregar_dinero, 1'b0);
      check1({tag, "_fondos"}, fondos_insuficientes, 1'b0);
      check1({tag, "_sesion"}, sesion_expirada, 1'b0);
   endtask

   task automatic card();
      tarjeta_recibida = 1'b1;
      tick();
      tarjeta_recibida = 1'b0;
   endtask

   // Enters a PIN and checks the verdict two cycles after the last digit strobe.
   task automatic do_pin(input logic [15:0] p);
      logic wrong;
      wrong = (p != PIN_OK) && !m_bloq;
      for (int i = 0; i < PD; i++) begin
         digito     = p[15-4*i -: 4];
         digito_stb = 1'b1;
         tick();
      end
      digito_stb = 1'b0;
      digito     = 4'($urandom_range(0, 15));
      check1("pin_inc_early", pin_incorrecto, 1'b0);
      tick();
      if (!m_bloq) begin
         if (wrong) m_int++;
         else       m_int = 0;
         if (m_int == MI) m_bloq = 1'b1;
      end
      check1("pin_incorrecto", pin_incorrecto, wrong);
      check1("advertencia", advertencia, (MI - m_int) == 1);
      check1("bloqueo", bloqueo, m_bloq);
      tick();
      check1("pin_inc_width", pin_incorrecto, 1'b0);
   endtask

   task automatic model_trans(input logic tipo, input logic [31:0] m, input logic [63:0] b,
                              output logic [63:0] e_bal, output logic e_stb,
                              output logic e_ent, output logic e_fon);
      logic [63:0] m64;
      m64   = 64'(m);
      e_bal = m_bal;
      e_stb = 1'b0;
      e_ent = 1'b0;
      e_fon = 1'b0;
      if (tipo) begin
         if (m64 > b) e_fon = 1'b1;
         else begin
            e_bal = b - m64;
            e_stb = 1'b1;
            e_ent = 1'b1;
         end
      end else begin
         e_bal = (b > TOPE - m64) ? TOPE : b + m64;
         e_stb = 1'b1;
      end
   endtask

   task automatic run_trans(input logic tipo, input logic [31:0] m, input logic [63:0] b,
                            input logic [63:0] e_bal, input logic e_stb,
                            input logic e_ent, input logic e_fon);
      tipo_trans      = tipo;
      monto           = m;
      balance_inicial = b;
      monto_stb       = 1'b1;
      tick();
      monto_stb       = 1'b0;
      monto           = $urandom();
      balance_inicial = {$urandom(), $urandom()};
      tipo_trans      = ~tipo;
      check1("stb_early", balance_stb | entregar_dinero | fondos_insuficientes, 1'b0);
      tick();
      check1("balance_stb", balance_stb, e_stb);
      check1("entregar_dinero", entregar_dinero, e_ent);
      check1("fondos_insuficientes", fondos_insuficientes, e_fon);
      check64("balance_actualizado", balance_actualizado, e_bal);
      tick();
      check1("pulse_clear", balance_stb | entregar_dinero | fondos_insuficientes, 1'b0);
      check64("balance_hold", balance_actualizado, e_bal);
      m_bal = e_bal;
   endtask

   task automatic apply_reset(input string tag);
      reset = 1'b0;
      #2;
      check_all_zero(tag);
      tick();
      reset  = 1'b1;
      m_int  = 0;
      m_bloq = 1'b0;
      m_bal  = '0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] e_bal;
      logic        e_stb, e_ent, e_fon;
      logic        tp;
      logic [31:0] m;
      logic [63:0] b;

      tabla[0] = '{1'b0, 32'd500,        64'd1000,                 64'd1500,                 1'b1, 1'b0, 1'b0};
      tabla[1] = '{1'b1, 32'd300,        64'd1000,                 64'd700,                  1'b1, 1'b1, 1'b0};
      tabla[2] = '{1'b1, 32'd2000,       64'd1000,                 64'd700,                  1'b0, 1'b0, 1'b1};
      tabla[3] = '{1'b0, 32'd1,          TOPE,                     TOPE,                     1'b1, 1'b0, 1'b0};
      tabla[4] = '{1'b1, 32'd1000,       64'd1000,                 64'd0,                    1'b1, 1'b1, 1'b0};
      tabla[5] = '{1'b0, 32'hFFFF_FFFF,  64'hFFFF_FFFF_0000_0001,  TOPE,                     1'b1, 1'b0, 1'b0};
      tabla[6] = '{1'b0, 32'hFFFF_FFFF,  64'hFFFF_FFFF_0000_0000,  TOPE,                     1'b1, 1'b0, 1'b0};

      // Reset state, then stray strobes in IDLE must do nothing.
      tick();
      check_all_zero("reset");
      reset = 1'b1;
      tick();
      digito_stb = 1'b1; digito = 4'd1; monto_stb = 1'b1;
      tick();
      tick();
      digito_stb = 1'b0; monto_stb = 1'b0;
      tick();
      check_all_zero("idle_strobes");

      for (int i = 0; i < 7; i++) begin
         card();
         do_pin(PIN_OK);
         run_trans(tabla[i].tipo, tabla[i].monto, tabla[i].bal,
                   tabla[i].e_bal, tabla[i].e_stb, tabla[i].e_ent, tabla[i].e_fon);
      end

      for (int it = 0; it < 30; it++) begin
         int nw;
         nw = $urandom_range(0, MI - 1);
         card();
         for (int w = 0; w < nw; w++) do_pin(PIN_OK ^ 16'($urandom_range(1, 65535)));
         do_pin(PIN_OK);
         tp = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 2))
            0: begin m = 32'($urandom_range(0, 5000)); b = 64'($urandom_range(0, 5000)); end
            1: begin m = $urandom(); b = TOPE - 64'($urandom_range(0, 100000)); end
            default: begin m = $urandom(); b = {$urandom(), $urandom()}; end
         endcase
         model_trans(tp, m, b, e_bal, e_stb, e_ent, e_fon);
         run_trans(tp, m, b, e_bal, e_stb, e_ent, e_fon);
      end

      // Reset mid-PIN after one failure: attempt count must restart from zero.
      card();
      do_pin(16'h9999);
      digito_stb = 1'b1; digito = 4'd1;
      tick();
      digito = 4'd2;
      tick();
      digito_stb = 1'b0;
      apply_reset("rst_mid_pin");
      card();
      do_pin(16'h1235);
      do_pin(16'h0000);
      do_pin(PIN_OK);
      run_trans(1'b0, 32'd5, 64'd10, 64'd15, 1'b1, 1'b0, 1'b0);

      // Three failures lock the card; later correct PIN and requests are ignored.
      card();
      do_pin(16'h4321);
      do_pin(16'hABCD);
      do_pin(16'h1230);
      do_pin(PIN_OK);
      tipo_trans = 1'b0; monto = 32'd1; balance_inicial = 64'd1; monto_stb = 1'b1;
      tarjeta_recibida = 1'b1;
      tick();
      monto_stb = 1'b0; tarjeta_recibida = 1'b0;
      tick();
      tick();
      check1("lock_no_stb", balance_stb, 1'b0);
      check1("lock_no_inc", pin_incorrecto, 1'b0);
      check1("lock_bloqueo", bloqueo, 1'b1);
      check64("lock_balance", balance_actualizado, 64'd15);
      apply_reset("rst_lock");
      card();
      do_pin(PIN_OK);
      run_trans(1'b1, 32'd40, 64'd100, 64'd60, 1'b1, 1'b1, 1'b0);

`ifdef SESION_TIMEOUT_EN
      begin
         bit seen;
         seen = 1'b0;
         card();
         do_pin(PIN_OK);
         for (int k = 0; k < 40 && !seen; k++) begin
            if (sesion_expirada) seen = 1'b1;
            else tick();
         end
         check1("sesion_expirada_seen", seen, 1'b1);
         tick();
         check1("sesion_expirada_width", sesion_expirada, 1'b0);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
